// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file with trap/MRET redirect sequencing.
// Holds the M-mode CSRs and 64-bit counters, and sequences trap entry and return.
module csr_trap_ctrl #(
  parameter int          XLEN        = 32,
  parameter int          NUM_IRQ     = 16,
  parameter bit          VECTORED    = 1'b1,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               csr_en_i,
  input  logic [1:0]         csr_op_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [XLEN-1:0]    csr_wdata_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  output logic               csr_illegal_o,
  input  logic               instr_retire_i,
  input  logic               exception_i,
  input  logic [XLEN-1:0]    exception_pc_i,
  input  logic [XLEN-1:0]    exception_cause_i,
  input  logic [XLEN-1:0]    exception_tval_i,
  input  logic               mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [XLEN-1:0]    irq_pc_i,
  output logic               trap_taken_o,
  output logic [XLEN-1:0]    trap_pc_o,
  output logic               mie_o
);

  localparam logic [XLEN-1:0] MIE_MASK =
    XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << 16);
  localparam logic [XLEN-1:0] MTVEC_MASK =
    VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t state_q, state_d;

  logic            mstat_mie_q;
  logic            mstat_mpie_q;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [63:0]     mcycle_q;
  logic [63:0]     minstret_q;
  logic            trap_taken_q;
  logic [XLEN-1:0] trap_pc_q;

  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] rd_val;
  logic            rd_hit;
  logic            wr_intent;
  logic            illegal;
  logic [XLEN-1:0] wr_val;
  logic            csr_we;

  logic [NUM_IRQ-1:0] pend;
  logic [4:0]         irq_idx;
  logic [4:0]         irq_code;
  logic               run;
  logic               take_exc;
  logic               take_mret;
  logic               take_irq;
  logic               take_trap;
  logic               event_any;
  logic [XLEN-1:0]    target;

  assign mip = XLEN'({irq_i, 16'h0000});

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (csr_addr_i)
      12'h300: rd_val = {24'd0, mstat_mpie_q, 3'd0, mstat_mie_q, 3'd0};
      12'h304: rd_val = mie_q;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h343: rd_val = mtval_q;
      12'h344: rd_val = mip;
      12'hB00: rd_val = mcycle_q[31:0];
      12'hB80: rd_val = mcycle_q[63:32];
      12'hB02: rd_val = minstret_q[31:0];
      12'hB82: rd_val = minstret_q[63:32];
      default: rd_hit = 1'b0;
    endcase
  end

  // set/clear with an all-zero operand is a pure read
  assign wr_intent = (csr_op_i == 2'b01) |
                     (csr_op_i[1] & (|csr_wdata_i));

  assign illegal = csr_en_i &
    (~rd_hit | ((csr_addr_i == 12'h344) & wr_intent));

  assign csr_illegal_o = illegal;
  assign csr_rdata_o   = illegal ? '0 : rd_val;

  always_comb begin
    case (csr_op_i)
      2'b01:   wr_val = csr_wdata_i;
      2'b10:   wr_val = rd_val | csr_wdata_i;
      2'b11:   wr_val = rd_val & ~csr_wdata_i;
      default: wr_val = rd_val;
    endcase
  end

  assign pend = irq_i & mie_q[16 +: NUM_IRQ];

  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_idx = 5'(i);
    end
  end

  assign irq_code = 5'd16 + irq_idx;

  assign run       = (state_q == RUN);
  assign take_exc  = run & exception_i;
  assign take_mret = run & ~exception_i & mret_i;
  assign take_irq  = run & ~exception_i & ~mret_i & ~csr_en_i &
                     mstat_mie_q & (|pend);
  assign take_trap = take_exc | take_irq;
  assign event_any = take_trap | take_mret;

  // a redirect or MRET in the same cycle drops the CSR write
  assign csr_we = run & csr_en_i & wr_intent & ~illegal &
                  ~exception_i & ~mret_i;

  always_comb begin
    target = trap_pc_q;
    unique case (1'b1)
      take_exc:  target = {mtvec_q[XLEN-1:2], 2'b00};
      take_mret: target = mepc_q;
      take_irq: begin
        target = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[0]) target = target + {25'd0, irq_code, 2'b00};
      end
      default: target = trap_pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (event_any) state_d = REDIRECT;
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      trap_taken_q <= 1'b0;
      trap_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      trap_taken_q <= event_any;
      trap_pc_q    <= target;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstat_mie_q  <= 1'b0;
      mstat_mpie_q <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      if (take_trap) begin
        mstat_mpie_q <= mstat_mie_q;
        mstat_mie_q  <= 1'b0;
      end else if (take_mret) begin
        mstat_mie_q  <= mstat_mpie_q;
        mstat_mpie_q <= 1'b1;
      end else if (csr_we && csr_addr_i == 12'h300) begin
        mstat_mie_q  <= wr_val[3];
        mstat_mpie_q <= wr_val[7];
      end
      if (take_exc) begin
        mepc_q   <= exception_pc_i & ~32'h3;
        mcause_q <= exception_cause_i;
        mtval_q  <= exception_tval_i;
      end else if (take_irq) begin
        mepc_q   <= irq_pc_i & ~32'h3;
        mcause_q <= {1'b1, 26'd0, irq_code};
        mtval_q  <= '0;
      end else if (csr_we) begin
        case (csr_addr_i)
          12'h341: mepc_q   <= wr_val & ~32'h3;
          12'h342: mcause_q <= wr_val;
          12'h343: mtval_q  <= wr_val;
          default: ;
        endcase
      end
      if (csr_we) begin
        case (csr_addr_i)
          12'h304: mie_q      <= wr_val & MIE_MASK;
          12'h305: mtvec_q    <= wr_val & MTVEC_MASK;
          12'h340: mscratch_q <= wr_val;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_we && csr_addr_i == 12'hB00) begin
        mcycle_q[31:0] <= wr_val;
      end else if (csr_we && csr_addr_i == 12'hB80) begin
        mcycle_q[63:32] <= wr_val;
      end else begin
        mcycle_q <= mcycle_q + 64'd1;
      end
      if (csr_we && csr_addr_i == 12'hB02) begin
        minstret_q[31:0] <= wr_val;
      end else if (csr_we && csr_addr_i == 12'hB82) begin
        minstret_q[63:32] <= wr_val;
      end else if (instr_retire_i) begin
        minstret_q <= minstret_q + 64'd1;
      end
    end
  end

  assign trap_taken_o = trap_taken_q;
  assign trap_pc_o    = trap_pc_q;
  assign mie_o        = mstat_mie_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: per-cycle model compare plus directed literal checks.
module tb_csr_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        csr_en_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        instr_retire_i;
  logic        exception_i;
  logic [31:0] exception_pc_i;
  logic [31:0] exception_cause_i;
  logic [31:0] exception_tval_i;
  logic        mret_i;
  logic [15:0] irq_i;
  logic [31:0] irq_pc_i;
  logic        trap_taken_o;
  logic [31:0] trap_pc_o;
  logic        mie_o;

  int total = 0;
  int bad   = 0;

  csr_trap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .csr_en_i(csr_en_i), .csr_op_i(csr_op_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .instr_retire_i(instr_retire_i),
    .exception_i(exception_i), .exception_pc_i(exception_pc_i),
    .exception_cause_i(exception_cause_i),
    .exception_tval_i(exception_tval_i),
    .mret_i(mret_i), .irq_i(irq_i), .irq_pc_i(irq_pc_i),
    .trap_taken_o(trap_taken_o), .trap_pc_o(trap_pc_o),
    .mie_o(mie_o)
  );

  always #10 clk_i = ~clk_i;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endfunction

  // architectural model
  bit          m_mie, m_mpie, m_tt;
  logic [31:0] m_mier, m_mtvec, m_scr, m_mepc, m_cause, m_tval, m_tpc;
  logic [63:0] m_cyc, m_ins;

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0; m_tt = 0;
    m_mier = 0; m_mtvec = 0; m_scr = 0; m_mepc = 0;
    m_cause = 0; m_tval = 0; m_tpc = 0; m_cyc = 0; m_ins = 0;
  endfunction

  function automatic logic [32:0] mread(logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'(m_mie) * 8 + 32'(m_mpie) * 128};
      12'h304: return {1'b1, m_mier};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_scr};
      12'h341: return {1'b1, m_mepc & ~32'h3};
      12'h342: return {1'b1, m_cause};
      12'h343: return {1'b1, m_tval};
      12'h344: return {1'b1, 32'(irq_i) << 16};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hB02: return {1'b1, m_ins[31:0]};
      12'hB82: return {1'b1, m_ins[63:32]};
      default: return 33'd0;
    endcase
  endfunction

  initial begin
    logic [32:0] r;
    logic [31:0] val, base;
    bit intent, ill, wr, cw, iw, n_tt;
    bit n_mie, n_mpie;
    logic [31:0] n_mier, n_mtvec, n_scr, n_mepc, n_cause, n_tval, n_tpc;
    logic [63:0] n_cyc, n_ins;
    logic [15:0] pend;
    int k;
    m_reset();
    forever begin
      @(negedge clk_i);
      if (rst_i) m_reset();
      r = mread(csr_addr_i);
      intent = (csr_op_i == 2'b01) || (csr_op_i[1] && csr_wdata_i != 0);
      ill = csr_en_i && (!r[32] || (csr_addr_i == 12'h344 && intent));
      chk("rdata", csr_rdata_o, ill ? 32'd0 : r[31:0]);
      chk("illegal", 32'(csr_illegal_o), 32'(ill));
      chk("trap_taken", 32'(trap_taken_o), 32'(m_tt));
      chk("trap_pc", trap_pc_o, m_tpc);
      chk("mie_o", 32'(mie_o), 32'(m_mie));
      n_mie = m_mie; n_mpie = m_mpie; n_mier = m_mier;
      n_mtvec = m_mtvec; n_scr = m_scr; n_mepc = m_mepc;
      n_cause = m_cause; n_tval = m_tval; n_tpc = m_tpc;
      n_cyc = m_cyc; n_ins = m_ins; n_tt = 0; cw = 0; iw = 0;
      wr = csr_en_i && intent && !ill && !m_tt &&
           !exception_i && !mret_i;
      if (wr) begin
        case (csr_op_i)
          2'b01:   val = csr_wdata_i;
          2'b10:   val = r[31:0] | csr_wdata_i;
          default: val = r[31:0] & ~csr_wdata_i;
        endcase
        case (csr_addr_i)
          12'h300: begin n_mie = val[3]; n_mpie = val[7]; end
          12'h304: n_mier = val & 32'hFFFF_0000;
          12'h305: n_mtvec = val & ~32'h2;
          12'h340: n_scr = val;
          12'h341: n_mepc = val;
          12'h342: n_cause = val;
          12'h343: n_tval = val;
          12'hB00: begin n_cyc[31:0] = val; cw = 1; end
          12'hB80: begin n_cyc[63:32] = val; cw = 1; end
          12'hB02: begin n_ins[31:0] = val; iw = 1; end
          12'hB82: begin n_ins[63:32] = val; iw = 1; end
          default: ;
        endcase
      end
      if (!cw) n_cyc = m_cyc + 1;
      if (!iw && instr_retire_i) n_ins = m_ins + 1;
      base = {m_mtvec[31:2], 2'b00};
      pend = irq_i & m_mier[31:16];
      if (!m_tt) begin
        if (exception_i) begin
          n_tt = 1; n_tpc = base;
          n_mepc = exception_pc_i; n_cause = exception_cause_i;
          n_tval = exception_tval_i; n_mpie = m_mie; n_mie = 0;
        end else if (mret_i) begin
          n_tt = 1; n_tpc = m_mepc & ~32'h3;
          n_mie = m_mpie; n_mpie = 1;
        end else if (m_mie && !csr_en_i && pend != 0) begin
          k = 0;
          while (!pend[k]) k++;
          n_tt = 1;
          n_tpc = base + (m_mtvec[0] ? 32'(4 * (16 + k)) : 32'd0);
          n_mepc = irq_pc_i; n_cause = 32'h8000_0000 + 32'(16 + k);
          n_tval = 0; n_mpie = m_mie; n_mie = 0;
        end
      end
      @(posedge clk_i);
      if (!rst_i) begin
        m_mie = n_mie; m_mpie = n_mpie; m_mier = n_mier;
        m_mtvec = n_mtvec; m_scr = n_scr; m_mepc = n_mepc;
        m_cause = n_cause; m_tval = n_tval; m_tpc = n_tpc;
        m_cyc = n_cyc; m_ins = n_ins; m_tt = n_tt;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] d);
    csr_en_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    step();
    csr_en_i = 0; csr_op_i = 0; csr_wdata_i = 0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp,
                    input string nm);
    csr_en_i = 1; csr_op_i = 0; csr_addr_i = a;
    #1;
    chk(nm, csr_rdata_o, exp);
    csr_en_i = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; csr_en_i = 0; csr_op_i = 0; csr_addr_i = 12'h300;
    csr_wdata_i = 0; instr_retire_i = 0; exception_i = 0;
    exception_pc_i = 0; exception_cause_i = 0; exception_tval_i = 0;
    mret_i = 0; irq_i = 0; irq_pc_i = 0;
    repeat (3) step();
    chk("rst_tt", 32'(trap_taken_o), 0);
    chk("rst_tpc", trap_pc_o, 0);
    rd(12'h305, 32'h0, "rst_mtvec");
    rd(12'h300, 32'h0, "rst_mstatus");
    rst_i = 0;
    step();

    // exception entry
    csr_wr(2'b01, 12'h305, 32'h100);
    exception_i = 1; exception_pc_i = 32'h200;
    exception_cause_i = 11; exception_tval_i = 32'h55;
    step();
    exception_i = 0;
    chk("exc_tt", 32'(trap_taken_o), 1);
    chk("exc_tpc", trap_pc_o, 32'h100);
    rd(12'h341, 32'h200, "exc_mepc");
    rd(12'h342, 32'd11, "exc_mcause");
    rd(12'h343, 32'h55, "exc_mtval");
    step();
    chk("exc_tt_drop", 32'(trap_taken_o), 0);

    // vectored interrupt
    csr_wr(2'b01, 12'h305, 32'h103);
    rd(12'h305, 32'h101, "mtvec_bit1");
    csr_wr(2'b01, 12'h300, 32'h8);
    csr_wr(2'b10, 12'h304, 32'h0004_000F);
    rd(12'h304, 32'h0004_0000, "mie_mask");
    irq_pc_i = 32'h400; irq_i = 16'h0006;
    step();
    irq_i = 0;
    chk("irq_tt", 32'(trap_taken_o), 1);
    chk("irq_tpc", trap_pc_o, 32'h148);
    chk("irq_mie", 32'(mie_o), 0);
    rd(12'h342, 32'h8000_0012, "irq_mcause");
    rd(12'h341, 32'h400, "irq_mepc");
    rd(12'h300, 32'h80, "irq_mstatus");
    step();

    // return
    mret_i = 1;
    step();
    mret_i = 0;
    chk("mret_tt", 32'(trap_taken_o), 1);
    chk("mret_tpc", trap_pc_o, 32'h400);
    chk("mret_mie", 32'(mie_o), 1);
    rd(12'h300, 32'h88, "mret_mstatus");
    step();

    // exception beats mret; second exception in redirect ignored
    exception_i = 1; mret_i = 1;
    exception_pc_i = 32'h600; exception_cause_i = 2;
    step();
    mret_i = 0;
    exception_pc_i = 32'h700; exception_cause_i = 5;
    chk("em_tpc", trap_pc_o, 32'h100);
    chk("em_mie", 32'(mie_o), 0);
    step();
    exception_i = 0;
    chk("em_tt2", 32'(trap_taken_o), 0);
    rd(12'h342, 32'd2, "em_mcause");
    rd(12'h341, 32'h600, "em_mepc");

    // counter carry and mip
    csr_wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_wr(2'b01, 12'hB80, 32'h0);
    rd(12'hB80, 32'h0, "cyc_hi0");
    rd(12'hB00, 32'hFFFF_FFFF, "cyc_lo");
    step();
    rd(12'hB80, 32'h1, "cyc_hi1");
    rd(12'hB00, 32'h0, "cyc_lo0");
    irq_i = 16'h0003;
    csr_en_i = 1; csr_op_i = 2'b01; csr_addr_i = 12'h344;
    csr_wdata_i = 32'h5;
    #1;
    chk("mip_ill", 32'(csr_illegal_o), 1);
    chk("mip_ill_rd", csr_rdata_o, 0);
    step();
    csr_op_i = 2'b10; csr_wdata_i = 0;
    #1;
    chk("mip_set0", 32'(csr_illegal_o), 0);
    chk("mip_val", csr_rdata_o, 32'h0003_0000);
    csr_op_i = 0; csr_addr_i = 12'h123;
    #1;
    chk("unmapped", 32'(csr_illegal_o), 1);
    csr_en_i = 0;
    step();
    irq_i = 0;
    instr_retire_i = 1;
    repeat (3) step();
    instr_retire_i = 0;
    rd(12'hB02, 32'd3, "instret");
    csr_addr_i = 12'hB00;
    repeat (2) step();

    // reset during redirect
    exception_i = 1; exception_pc_i = 32'h800;
    step();
    exception_i = 0;
    chk("pre_rst_tt", 32'(trap_taken_o), 1);
    #1;
    rst_i = 1;
    #1;
    chk("rst_abort_tt", 32'(trap_taken_o), 0);
    chk("rst_abort_tpc", trap_pc_o, 0);
    rd(12'h305, 32'h0, "rst_abort_mtvec");
    rd(12'h341, 32'h0, "rst_abort_mepc");
    step();
    rst_i = 0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 Parameter XLEN, 32, data and CSR width; only 32 supported.
REQ-002 Parameter NUM_IRQ, 16, local interrupt lines (1..16), mapped to mip/mie bits 16+k.
REQ-003 Parameter VECTORED, 1, mtvec vectored mode allowed when 1; mtvec.MODE hardwired 0 when 0.
REQ-004 Parameter MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
REQ-005 One clock; reset is asynchronous and active-high: clk_i input 1 clock; rst_i input 1 asynchronous active-high reset.
REQ-006 csr_en_i  in  1  CSR access this cycle.
REQ-007 csr_op_i  in  2  01 write, 10 set-bits, 11 clear-bits, 00 read-only.
REQ-008 csr_addr_i  in  12  CSR address.
REQ-009 csr_wdata_i  in  XLEN  write/set/clear operand.
REQ-010 csr_rdata_o  out  XLEN  current value of addressed CSR, combinational.
REQ-011 csr_illegal_o  out  1  access to unimplemented or read-only CSR with write intent, combinational.
REQ-012 instr_retire_i  in  1  one instruction retired.
REQ-013 exception_i, exception_pc_i (XLEN), exception_cause_i (XLEN), exception_tval_i (XLEN)  in  synchronous exception request and data.
REQ-014 mret_i  in  1  MRET executed.
REQ-015 irq_i  in  NUM_IRQ  level-sensitive interrupt lines; irq_pc_i  in  XLEN  resume PC for interrupts.
REQ-016 trap_taken_o  out  1  redirect strobe; trap_pc_o  out  XLEN  redirect target; mie_o  out  1  mstatus.MIE.

Function
REQ-017 CSR map: mstatus 0x300 (bit3 MIE, bit7 MPIE, rest 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits1:0 read 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only mirror of irq_i), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
REQ-018 Write value: op 01 wdata, 10 old|wdata, 11 old&~wdata; op 00 writes nothing; set/clear with wdata=0 is not write intent.
REQ-019 Illegal access (unmapped address, or write intent to mip) raises csr_illegal_o, performs no write, csr_rdata_o = 0.
REQ-020 mie bits outside [16+NUM_IRQ-1:16] and mtvec bit1 read 0; mtvec bit0 writable only if VECTORED.
REQ-021 mcycle (64 bit) increments every cycle; minstret (64 bit) increments when instr_retire_i; both wrap 2^64-1 -> 0; CSR write to either half replaces that half and suppresses increment that cycle.
REQ-022 FSM states RUN, REDIRECT; RUN -> REDIRECT on trap entry or MRET; REDIRECT -> RUN unconditionally after one cycle.
REQ-023 In REDIRECT, exception_i, mret_i, irq_i and CSR writes are ignored; counters keep running.
REQ-024 Priority in RUN: exception_i > mret_i > interrupt; lower irq index wins among interrupts.
REQ-025 Interrupt taken when MIE=1, (mip & mie) != 0, and csr_en_i, exception_i, mret_i all low that cycle.
REQ-026 Trap entry (edge): mepc <= exception_pc_i or irq_pc_i; mcause <= exception_cause_i or {1'b1, 16+k}; mtval <= exception_tval_i or 0; MPIE <= MIE; MIE <= 0.
REQ-027 Trap target: {mtvec[31:2],2'b00}; plus 4*(16+k) when interrupt and mtvec.MODE=1.
REQ-028 MRET (edge): MIE <= MPIE; MPIE <= 1; target = mepc.
REQ-029 trap_taken_o is registered: high exactly one cycle (REDIRECT) after event, with trap_pc_o holding target; trap_pc_o holds last target otherwise.
REQ-030 Exception with simultaneous CSR write: exception wins, write dropped.

Reset
REQ-031 While rst_i high, asynchronously: FSM RUN, trap_taken_o 0, trap_pc_o 0, mie_o 0, mtvec MTVEC_RESET, all other CSRs and counters 0; reset mid-REDIRECT aborts redirect.

Verification
REQ-032 Write 0x305 op01 0x100, then exception pc 0x200 cause 11 -> next cycle trap_taken_o=1, trap_pc_o 0x100, mepc 0x200, mcause 11.
REQ-033 mtvec 0x101, MIE=1, mie bit18 set, irq_i[2]=1 -> trap_pc_o 0x148, mcause 0x8000_0012, mie_o 0.
REQ-034 MIE=1, then trap, then mret_i -> trap_pc_o = mepc, mie_o returns 1, MPIE 1.
REQ-035 Exception and mret_i same cycle -> exception taken; second exception during REDIRECT -> ignored.
REQ-036 Write mcycle 0xFFFF_FFFF, mcycleh 0 -> after two cycles mcycleh 1; op01 to 0x344 -> csr_illegal_o 1, mip unchanged.
REQ-037 Assert rst_i during REDIRECT -> trap_taken_o 0 immediately, mtvec MTVEC_RESET.
